// File: rtl/phase_cmd_pkg.sv
// phase_cmd_pkg: opcodes, parser FSM states and err_flags bit positions
package phase_cmd_pkg;
  typedef enum logic [7:0] {
    OP_WRITE    = 8'h01,
    OP_BURST    = 8'h02,
    OP_COMMIT   = 8'h03,
    OP_READBACK = 8'h04,
    OP_CLR_ERR  = 8'h05
  } opcode_e;
  typedef enum logic [2:0] {GET_OPC, GET_ADDR, GET_CNT, GET_PHASE, SEND_RB} state_e;
  localparam int ERR_OPC  = 0;
  localparam int ERR_ADDR = 1;
  localparam int ERR_TMO  = 2;
endpackage

// File: rtl/rx_byte_fetch.sv
// rx_byte_fetch: single-outstanding RX FIFO read handshake plus inter-byte timeout counter
module rx_byte_fetch #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_tmo_en,
  input  logic i_empty,
  input  logic i_valid,
  output logic o_rd,
  output logic o_vld,
  output logic o_timeout
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic          r_rd;
  logic          r_pend;
  logic [CW-1:0] r_cnt;
  logic          w_issue;
  assign w_issue   = i_en && !i_empty && !r_pend;
  assign o_rd      = r_rd;
  // a valid strobe only counts while our own read is still in flight
  assign o_vld     = r_pend && i_valid;
  assign o_timeout = i_tmo_en && !o_vld && (r_cnt == CW'(TIMEOUT_CYC - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd   <= 1'b0;
      r_pend <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_rd   <= w_issue;
      r_pend <= w_issue || (r_pend && !i_valid);
      r_cnt  <= (!i_tmo_en || o_vld || o_timeout) ? '0 : r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/phase_cmd_parser.sv
// phase_cmd_parser: decodes host byte commands into a shadow phase array, committed to the active array on COMMIT
module phase_cmd_parser
  import phase_cmd_pkg::*;
#(
  parameter int NUM_CHANNELS   = 64,
  parameter int PHASE_W        = 8,
  parameter int RX_FIFO_LOAD_W = 8,
  parameter int TX_FIFO_LOAD_W = 8,
  parameter int TIMEOUT_CYC    = 1024
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [7:0]                        rxfifo_data,
  input  logic                              rxfifo_valid,
  input  logic                              rxfifo_empty,
  input  logic [RX_FIFO_LOAD_W-1:0]         rxfifo_load,
  output logic                              rxfifo_rd,
  input  logic                              txfifo_full,
  input  logic [TX_FIFO_LOAD_W-1:0]         txfifo_load,
  output logic                              txfifo_wr,
  output logic [7:0]                        txfifo_data,
  output logic [NUM_CHANNELS*PHASE_W-1:0]   phases,
  output logic                              commit_pulse,
  output logic [2:0]                        err_flags
);
  localparam int AW = $clog2(NUM_CHANNELS);
  state_e                          r_state, w_next;
  logic [7:0]                      r_opc, r_rem;
  logic [AW-1:0]                   r_addr;
  logic                            r_bad, r_commit;
  logic [2:0]                      r_err, w_set;
  logic [NUM_CHANNELS*PHASE_W-1:0] r_shadow, r_phases;
  logic                            w_vld, w_tmo, w_commit, w_clr, w_we, w_tx, w_bad, w_unused;
  logic [PHASE_W-1:0]              w_rd_ph;
  assign w_unused = ^{rxfifo_load, txfifo_load};
  assign w_bad    = 9'(rxfifo_data) >= 9'(NUM_CHANNELS);
  assign w_rd_ph  = r_shadow[int'(r_addr)*PHASE_W +: PHASE_W];
  rx_byte_fetch #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_fetch (
    .clk       (clk),
    .rst       (rst),
    .i_en      (r_state != SEND_RB),
    .i_tmo_en  (r_state inside {GET_ADDR, GET_CNT, GET_PHASE}),
    .i_empty   (rxfifo_empty),
    .i_valid   (rxfifo_valid),
    .o_rd      (rxfifo_rd),
    .o_vld     (w_vld),
    .o_timeout (w_tmo)
  );
  always_comb begin
    w_next   = r_state;
    w_set    = '0;
    w_clr    = 1'b0;
    w_commit = 1'b0;
    w_we     = 1'b0;
    w_tx     = 1'b0;
    if (w_tmo) begin
      w_next         = GET_OPC;
      w_set[ERR_TMO] = 1'b1;
    end else begin
      case (r_state)
        GET_OPC: if (w_vld) begin
          w_next         = (rxfifo_data inside {OP_WRITE, OP_BURST, OP_READBACK}) ? GET_ADDR : GET_OPC;
          w_commit       = rxfifo_data == OP_COMMIT;
          w_clr          = rxfifo_data == OP_CLR_ERR;
          w_set[ERR_OPC] = !(rxfifo_data inside {OP_WRITE, OP_BURST, OP_COMMIT, OP_READBACK, OP_CLR_ERR});
        end
        GET_ADDR: if (w_vld) begin
          w_set[ERR_ADDR] = w_bad;
          w_next          = (r_opc == OP_WRITE) ? GET_PHASE : (r_opc == OP_BURST) ? GET_CNT : SEND_RB;
        end
        GET_CNT: if (w_vld) w_next = GET_PHASE;
        GET_PHASE: if (w_vld) begin
          w_we   = !r_bad;
          w_next = (r_rem == 8'h00) ? GET_OPC : GET_PHASE;
        end
        SEND_RB: if (!txfifo_full) begin
          w_tx   = 1'b1;
          w_next = GET_OPC;
        end
        default: w_next = GET_OPC;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= GET_OPC;
      r_opc    <= '0;
      r_rem    <= '0;
      r_addr   <= '0;
      r_bad    <= 1'b0;
      r_commit <= 1'b0;
      r_err    <= '0;
      r_shadow <= '0;
      r_phases <= '0;
    end else begin
      r_state  <= w_next;
      r_commit <= w_commit;
      r_err    <= (w_clr ? 3'b000 : r_err) | w_set;
      if (w_commit) r_phases <= r_shadow;
      if (w_we) r_shadow[int'(r_addr)*PHASE_W +: PHASE_W] <= rxfifo_data[PHASE_W-1:0];
      if (w_vld && r_state == GET_OPC) r_opc <= rxfifo_data;
      if (w_vld && r_state == GET_ADDR) begin
        r_addr <= rxfifo_data[AW-1:0];
        r_bad  <= w_bad;
        r_rem  <= 8'h00;
      end
      if (w_vld && r_state == GET_CNT) r_rem <= rxfifo_data;
      // burst walks the channel ring, wrapping past the last channel
      if (w_vld && r_state == GET_PHASE) begin
        r_addr <= (r_addr == AW'(NUM_CHANNELS - 1)) ? '0 : r_addr + 1'b1;
        r_rem  <= r_rem - 1'b1;
      end
    end
  end
  assign phases       = r_phases;
  assign commit_pulse = r_commit;
  assign err_flags    = r_err;
  assign txfifo_wr    = w_tx;
  assign txfifo_data  = (w_tx && !r_bad) ? 8'(w_rd_ph) : 8'h00;
endmodule

// File: tb/tb_phase_cmd_parser.sv
// tb_phase_cmd_parser: directed vector table, corner-case sequences and random commands against a byte-stream model
module tb_phase_cmd_parser;
  localparam int NC = 16, PW = 5, TC = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] rxfifo_data = 8'h00;
  logic rxfifo_valid = 1'b0, rxfifo_empty = 1'b1, txfifo_full = 1'b0;
  logic [7:0] rxfifo_load = 8'h00, txfifo_load = 8'h00;
  logic rxfifo_rd, txfifo_wr, commit_pulse;
  logic [7:0] txfifo_data;
  logic [NC*PW-1:0] phases;
  logic [2:0] err_flags;

  phase_cmd_parser #(.NUM_CHANNELS(NC), .PHASE_W(PW), .RX_FIFO_LOAD_W(8), .TX_FIFO_LOAD_W(8), .TIMEOUT_CYC(TC)) dut (
    .clk(clk), .rst(rst), .rxfifo_data(rxfifo_data), .rxfifo_valid(rxfifo_valid), .rxfifo_empty(rxfifo_empty),
    .rxfifo_load(rxfifo_load), .rxfifo_rd(rxfifo_rd), .txfifo_full(txfifo_full), .txfifo_load(txfifo_load),
    .txfifo_wr(txfifo_wr), .txfifo_data(txfifo_data), .phases(phases), .commit_pulse(commit_pulse), .err_flags(err_flags));

  always #5 clk = ~clk;

  logic [7:0] q[$];
  logic [7:0] tx_got[$];
  logic [7:0] hold, stray_b;
  int lat = 0, cd = 0, n_commit = 0, n_wr_full = 0;
  bit infl = 0, stray = 0, rand_full = 0, force_full = 0;

  // RX FIFO model: answers each read with its byte after lat extra cycles; also monitors TX and commit
  always @(negedge clk) begin
    rxfifo_valid = 1'b0;
    if (rxfifo_rd && q.size() > 0) begin
      hold = q.pop_front();
      cd = lat;
      infl = 1;
    end
    if (infl) begin
      if (cd == 0) begin
        rxfifo_valid = 1'b1;
        rxfifo_data = hold;
        infl = 0;
      end else cd--;
    end else if (stray) begin
      rxfifo_valid = 1'b1;
      rxfifo_data = stray_b;
      stray = 0;
    end
    rxfifo_empty = (q.size() == 0);
    if (txfifo_wr) begin
      tx_got.push_back(txfifo_data);
      if (txfifo_full) n_wr_full++;
    end
    if (commit_pulse) n_commit++;
  end

  always @(posedge clk) begin
    #1;
    txfifo_full = rand_full ? ($urandom_range(0, 1) == 1) : force_full;
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(string nm, logic [127:0] got, logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic push_bytes(logic [63:0] b, int n);
    for (int k = 0; k < n; k++) q.push_back(b[8*(n-1-k) +: 8]);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((q.size() > 0 || infl) && t < 2000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 2000) begin
      n_chk++;
      $display("FAIL idle_bound: FIFO still busy after %0d cycles, required drained", t);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [63:0] b;
    int n;
    int ch;
    logic [4:0] ph;
    logic [2:0] err;
  } vec_t;
  vec_t tbl[17];

  logic [4:0] m_sh[NC], m_ph[NC];
  logic [2:0] m_err;
  logic [7:0] exp_tx[$];
  logic [NC*PW-1:0] m_vec;
  logic [7:0] p, o;
  int a, n, op, exp_commit, cyc;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{64'h01031F, 3, 3, 5'd0, 3'b000};
    tbl[1]  = '{64'h03, 1, 3, 5'd31, 3'b000};
    tbl[2]  = '{64'h020E0301020304, 7, 14, 5'd0, 3'b000};
    tbl[3]  = '{64'h03, 1, 14, 5'd1, 3'b000};
    tbl[4]  = '{64'h0, 0, 15, 5'd2, 3'b000};
    tbl[5]  = '{64'h0, 0, 0, 5'd3, 3'b000};
    tbl[6]  = '{64'h0, 0, 1, 5'd4, 3'b000};
    tbl[7]  = '{64'h012007, 3, 0, 5'd3, 3'b010};
    tbl[8]  = '{64'h03, 1, 0, 5'd3, 3'b010};
    tbl[9]  = '{64'h01020703, 4, 2, 5'd7, 3'b010};
    tbl[10] = '{64'h05, 1, 2, 5'd7, 3'b000};
    tbl[11] = '{64'hAA, 1, 2, 5'd7, 3'b001};
    tbl[12] = '{64'h050105FF03, 5, 5, 5'd31, 3'b000};
    tbl[13] = '{64'h0210010909, 5, 0, 5'd3, 3'b010};
    tbl[14] = '{64'h01040A03, 4, 4, 5'd10, 3'b010};
    tbl[15] = '{64'h0, 0, 0, 5'd3, 3'b010};
    tbl[16] = '{64'h0, 0, 1, 5'd4, 3'b010};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_phases", phases, 0);
    chk("rst_err", err_flags, 0);
    chk("rst_strobes", {rxfifo_rd, txfifo_wr, commit_pulse}, 0);
    chk("rst_txdata", txfifo_data, 0);
    @(negedge clk);
    rst = 1'b0;

    n_commit = 0;
    for (int i = 0; i < 17; i++) begin
      push_bytes(tbl[i].b, tbl[i].n);
      wait_idle();
      chk($sformatf("vec%0d_phase", i), phases[tbl[i].ch*PW +: PW], tbl[i].ph);
      chk($sformatf("vec%0d_err", i), err_flags, tbl[i].err);
    end
    chk("commit_pulse_cycles", n_commit, 6);

    // readback held off by a full TX FIFO
    force_full = 1;
    tx_got.delete();
    push_bytes(64'h050403, 3);
    wait_idle();
    repeat (5) @(posedge clk);
    chk("rb_held_while_full", tx_got.size(), 0);
    force_full = 0;
    for (int t = 0; t < 20 && tx_got.size() == 0; t++) @(posedge clk);
    repeat (3) @(posedge clk);
    chk("rb_count", tx_got.size(), 1);
    chk("rb_data", tx_got.size() > 0 ? tx_got[0] : 8'hxx, 8'h1F);
    chk("rb_wr_while_full", n_wr_full, 0);
    tx_got.delete();
    push_bytes(64'h0420, 2);
    wait_idle();
    chk("rb_bad_count", tx_got.size(), 1);
    chk("rb_bad_data", tx_got.size() > 0 ? tx_got[0] : 8'hxx, 8'h00);
    chk("rb_bad_err", err_flags, 3'b010);

    // timeout while waiting for a burst count byte
    push_bytes(64'h05, 1);
    wait_idle();
    push_bytes(64'h0200, 2);
    cyc = 0;
    while ((q.size() > 0 || infl) && cyc < 100) begin
      @(posedge clk);
      cyc++;
    end
    cyc = 0;
    while (!err_flags[2] && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("tmo_latency_ok", (cyc >= 14 && cyc <= 18), 1);
    chk("tmo_err", err_flags, 3'b100);
    push_bytes(64'h01070903, 4);
    wait_idle();
    chk("tmo_then_write", phases[7*PW +: PW], 9);
    chk("tmo_err_sticky", err_flags, 3'b100);
    push_bytes(64'h05, 1);
    wait_idle();
    chk("clr_err", err_flags, 0);

    // unsolicited valid strobe must be ignored
    stray_b = 8'hAA;
    stray = 1;
    repeat (4) @(posedge clk);
    #1;
    chk("stray_valid_ignored", err_flags, 0);

    // reset mid-burst with the aborted read returning late
    lat = 3;
    push_bytes(64'h0201030A0B0C0D, 7);
    cyc = 0;
    while (cyc < 200) begin
      @(negedge clk);
      #1;
      cyc++;
      if (infl && cd == 2 && q.size() <= 3) break;
    end
    chk("rst_mid_reached", cyc < 200, 1);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    lat = 0;
    chk("midrst_phases", phases, 0);
    chk("midrst_late_valid_err", err_flags, 0);
    chk("midrst_strobes", {rxfifo_rd, txfifo_wr, commit_pulse}, 0);
    push_bytes(64'h01010503, 4);
    wait_idle();
    chk("midrst_after_write", phases[1*PW +: PW], 5);
    chk("midrst_shadow_cleared", phases[2*PW +: PW], 0);

    // random command streams against the byte-level model
    do_reset();
    for (int c = 0; c < NC; c++) begin
      m_sh[c] = '0;
      m_ph[c] = '0;
    end
    m_err = '0;
    rand_full = 1;
    n_wr_full = 0;
    for (int r = 0; r < 20; r++) begin
      tx_got.delete();
      exp_tx.delete();
      n_commit = 0;
      exp_commit = 0;
      lat = $urandom_range(0, 2);
      for (int k = 0; k < 8; k++) begin
        op = $urandom_range(0, 5);
        a = $urandom_range(0, 17);
        case (op)
          0: begin
            p = 8'($urandom);
            q.push_back(8'h01); q.push_back(8'(a)); q.push_back(p);
            if (a < NC) m_sh[a] = p[4:0]; else m_err[1] = 1'b1;
          end
          1: begin
            n = $urandom_range(0, 4);
            q.push_back(8'h02); q.push_back(8'(a)); q.push_back(8'(n));
            if (a >= NC) m_err[1] = 1'b1;
            for (int j = 0; j <= n; j++) begin
              p = 8'($urandom);
              q.push_back(p);
              if (a < NC) m_sh[(a + j) % NC] = p[4:0];
            end
          end
          2: begin
            q.push_back(8'h03);
            for (int c = 0; c < NC; c++) m_ph[c] = m_sh[c];
            exp_commit++;
          end
          3: begin
            q.push_back(8'h04); q.push_back(8'(a));
            exp_tx.push_back(a < NC ? {3'b000, m_sh[a]} : 8'h00);
            if (a >= NC) m_err[1] = 1'b1;
          end
          4: begin
            q.push_back(8'h05);
            m_err = '0;
          end
          default: begin
            o = (a % 4 == 0) ? 8'h00 : (a % 4 == 1) ? 8'h06 : (a % 4 == 2) ? 8'h7F : 8'hFF;
            q.push_back(o);
            m_err[0] = 1'b1;
          end
        endcase
      end
      cyc = 0;
      while ((q.size() > 0 || infl || tx_got.size() < exp_tx.size()) && cyc < 3000) begin
        @(posedge clk);
        cyc++;
      end
      repeat (4) @(posedge clk);
      #1;
      for (int c = 0; c < NC; c++) m_vec[c*PW +: PW] = m_ph[c];
      chk($sformatf("rnd%0d_phases", r), phases, m_vec);
      chk($sformatf("rnd%0d_err", r), err_flags, m_err);
      chk($sformatf("rnd%0d_commits", r), n_commit, exp_commit);
      chk($sformatf("rnd%0d_tx_count", r), tx_got.size(), exp_tx.size());
      for (int j = 0; j < exp_tx.size() && j < tx_got.size(); j++)
        chk($sformatf("rnd%0d_tx%0d", r, j), tx_got[j], exp_tx[j]);
    end
    rand_full = 0;
    chk("rnd_wr_while_full", n_wr_full, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
